superfx_alu_seq: RTL and testbench
==================================

// Module: superfx_alu_seq
// PURPOSE
//  Registered, parametrised successor to the combinational SuperFX ALU.
//  Executes one opcode per accepted request and registers Z/S/CY/OV flags internally, so ADC/SBC/ROR use stored carry.
//  Adds arithmetic/logical shifts, bit-clear and an optional iterative multiplier.
//  Sits between the register-file read buses (x, y) and the z writeback bus.
// PARAMETERS
//  WIDTH      16  data path width; must be >= 2 and even
//  IMM_WIDTH  8   immediate field width, zero-extended to WIDTH; must be <= WIDTH
// PORTS
//  clk        in   1          system clock, all state on rising edge
//  reset      in   1          synchronous, active-high reset
//  op_valid   in   1          request present
//  op_ready   out  1          block can accept a request this cycle
//  op         in   4          opcode (see BEHAVIOUR)
//  x          in   WIDTH      operand A
//  y          in   WIDTH      operand B
//  imm        in   IMM_WIDTH  immediate operand
//  y_src_sel  in   1          0: B = y; 1: B = {0, imm}
//  z          out  WIDTH      result, low half for MUL
//  z_hi       out  WIDTH      MUL high half; 0 for every other op
//  z_valid    out  1          one-cycle pulse, z/z_hi/flags valid
//  cy, ov, zf, sf  out  1     registered carry, overflow, zero, sign flags
// BEHAVIOUR
//  - Reset: z = z_hi = 0, z_valid = 0, all flags = 0, op_ready = 1, FSM = IDLE.
//  - Reset mid-MUL aborts the operation, with no z_valid pulse.
//  - Reset wins over a simultaneous accept.
//  - Accept = op_valid & op_ready. Operands are captured at accept; later input changes are ignored.
//  - FSM states: IDLE, MUL_BUSY.
//    - IDLE -> MUL_BUSY when MUL is accepted.
//    - MUL_BUSY -> IDLE after WIDTH iterations.
//    - op_ready = (state == IDLE).
//  - Single-cycle ops: result and flags are registered on the accept edge. z_valid is high the following cycle (latency 1).
//  - Back-to-back accepts are allowed every cycle.
//  - Opcodes:
//    - 0 ADD: A+B
//    - 1 SUB: A-B
//    - 2 ADC: A+B+cy
//    - 3 SBC: A-B-!cy
//    - 4 AND
//    - 5 OR
//    - 6 XOR
//    - 7 BIC: A&~B
//    - 8 ROR: {cy, A[W-1:1]}, cy <= A[0]
//    - 9 LSR: cy <= A[0]
//    - 10 ASR: cy <= A[0]
//    - 11 SWAP: half-word swap of A
//    - 12 MUL
//    - 13-15 NOP
//  - Arithmetic is computed at WIDTH+1 bits.
//    - Carry-out is cy; for SUB/SBC, cy = 1 means no borrow.
//    - ov = signed overflow (sign of A and B' equal, result sign differs).
//  - Flag updates:
//    - zf/sf: updated by every op except NOP.
//    - cy: updated by arith ops and shifts.
//    - ov: updated by arith ops only.
//    - Flags not listed for an op hold their value.
//  - NOP: z = 0, z_valid pulses (latency 1), all flags hold.
//  - MUL: unsigned WIDTH x WIDTH -> 2*WIDTH product, one shift-add step per cycle.
//    - z_valid asserts WIDTH cycles after accept (latency WIDTH).
//    - zf = (full product == 0); sf = z_hi[W-1]; cy and ov hold.
// CONFIGURATION
//  SUPERFX_ALU_MUL_EN defined: MUL is implemented as above.
//  SUPERFX_ALU_MUL_EN undefined:
//    - Opcode 12 decodes as NOP and MUL_BUSY is unreachable.
//    - z_hi is tied to 0 and op_ready stays 1 outside reset.
// STRUCTURE
//  Package superfx_alu_pkg holds:
//    - opcode localparams (OP_ADD..OP_MUL)
//    - FSM state encoding (ST_IDLE, ST_MUL_BUSY)
//    - flag bit indices
//  Sub-module superfx_alu_mul_iter: start/done shift-add engine with a WIDTH-cycle counter. It is instantiated only under SUPERFX_ALU_MUL_EN.
// TESTING
//  1. Reset held 2 cycles with op_valid=1 -> z=0, z_valid=0, flags=0, op_ready=1 throughout.
//  2. ADD x=16'hFFFF, y=16'h0001 -> next cycle: z=0, cy=1, zf=1, ov=0; then ADC x=1, y=1 -> z=3.
//  3. SUB x=16'h8000, y_src_sel=1, imm=8'h01 -> z=16'h7FFF, ov=1, cy=1, sf=0.
//  4. ROR x=16'h0001 with cy=1 -> z=16'h8000, cy=1; then ASR x=16'h8002 -> z=16'hC001, cy=0.
//  5. MUL (macro on) x=16'hFFFF, y=16'hFFFF -> op_ready=0 for 16 cycles; z_valid at cycle 16; z=16'h0001, z_hi=16'hFFFE; cy/ov unchanged.
//  6. Reset asserted at MUL cycle 5 -> no z_valid, op_ready=1 next cycle. With macro off, op=12 -> NOP with latency 1.

Source files
------------

// File: rtl/superfx_alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the registered SuperFX ALU.
package superfx_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADC  = 4'd2;
    localparam logic [3:0] OP_SBC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_BIC  = 4'd7;
    localparam logic [3:0] OP_ROR  = 4'd8;
    localparam logic [3:0] OP_LSR  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_SWAP = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    localparam int FLAG_CY = 0;
    localparam int FLAG_OV = 1;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_SF = 3;

endpackage

// File: rtl/superfx_alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH steps total.
// The first step is folded into the start cycle; last_o marks the cycle whose step completes the product.
module superfx_alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 last_o,
    output logic [2*WIDTH-1:0]   prod_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    // acc holds {high partial sum, unconsumed multiplier bits}; each step adds and shifts right.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] hi;
        hi = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        return {hi, p[WIDTH-1:1]};
    endfunction

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [CW-1:0]      cnt_q;

    assign acc_d  = mul_step(acc_q, mcand_q);
    assign prod_o = acc_d;
    assign busy_o = (cnt_q != '0);
    assign last_o = (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else if (start_i) begin
            mcand_q <= a_i;
            acc_q   <= mul_step({{WIDTH{1'b0}}, b_i}, a_i);
            cnt_q   <= CW'(WIDTH - 1);
        end else if (busy_o) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/superfx_alu_seq.sv
// Registered SuperFX ALU with stored Z/S/CY/OV flags and an optional iterative multiplier.
// Define SUPERFX_ALU_MUL_EN to build the multiplier; otherwise opcode 12 behaves as NOP.
module superfx_alu_seq
    import superfx_alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic                 y_src_sel,
    output logic [WIDTH-1:0]     z,
    output logic [WIDTH-1:0]     z_hi,
    output logic                 z_valid,
    output logic                 cy,
    output logic                 ov,
    output logic                 zf,
    output logic                 sf,
    output state_t               dbg_state_o
);
    state_t             state_q;
    logic [WIDTH-1:0]   z_q, z_hi_q;
    logic               z_valid_q;
    logic [3:0]         flags_q, flags_d;

    logic [WIDTH-1:0]   b_op, arith_b, res_z;
    logic [WIDTH:0]     sum;
    logic               sub_like, carry_like, cin, upd_zs, accept;
    logic               mul_start, mul_busy, mul_last;
    logic [2*WIDTH-1:0] mul_prod;

    // Handshake: a request transfers on a rising edge where op_valid and op_ready are both high.
    assign op_ready = (state_q == ST_IDLE);
    assign accept   = op_valid & op_ready;

    assign b_op       = y_src_sel ? WIDTH'(imm) : y;
    assign sub_like   = (op == OP_SUB) || (op == OP_SBC);
    assign carry_like = (op == OP_ADC) || (op == OP_SBC);
    assign arith_b    = sub_like ? ~b_op : b_op;
    assign cin        = carry_like ? flags_q[FLAG_CY] : sub_like;
    assign sum        = {1'b0, x} + {1'b0, arith_b} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        res_z   = '0;
        flags_d = flags_q;
        upd_zs  = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                res_z            = sum[WIDTH-1:0];
                flags_d[FLAG_CY] = sum[WIDTH];
                flags_d[FLAG_OV] = (x[WIDTH-1] == arith_b[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND:  res_z = x & b_op;
            OP_OR:   res_z = x | b_op;
            OP_XOR:  res_z = x ^ b_op;
            OP_BIC:  res_z = x & ~b_op;
            OP_ROR: begin
                res_z            = {flags_q[FLAG_CY], x[WIDTH-1:1]};
                flags_d[FLAG_CY] = x[0];
            end
            OP_LSR: begin
                res_z            = {1'b0, x[WIDTH-1:1]};
                flags_d[FLAG_CY] = x[0];
            end
            OP_ASR: begin
                res_z            = {x[WIDTH-1], x[WIDTH-1:1]};
                flags_d[FLAG_CY] = x[0];
            end
            OP_SWAP: res_z = {x[WIDTH/2-1:0], x[WIDTH-1:WIDTH/2]};
            default: upd_zs = 1'b0;
        endcase
        if (upd_zs) begin
            flags_d[FLAG_ZF] = (res_z == '0);
            flags_d[FLAG_SF] = res_z[WIDTH-1];
        end
    end

`ifdef SUPERFX_ALU_MUL_EN
    assign mul_start = accept && (op == OP_MUL);

    superfx_alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start_i (mul_start),
        .a_i     (x),
        .b_i     (b_op),
        .busy_o  (mul_busy),
        .last_o  (mul_last),
        .prod_o  (mul_prod)
    );
`else
    assign mul_start = 1'b0;
    assign mul_busy  = 1'b0;
    assign mul_last  = 1'b0;
    assign mul_prod  = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            z_q       <= '0;
            z_hi_q    <= '0;
            z_valid_q <= 1'b0;
            flags_q   <= '0;
        end else begin
            z_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mul_start) begin
                        state_q <= ST_MUL_BUSY;
                    end else if (accept) begin
                        z_q       <= res_z;
                        z_hi_q    <= '0;
                        z_valid_q <= 1'b1;
                        flags_q   <= flags_d;
                    end
                end
                ST_MUL_BUSY: begin
                    // Result lands on the final step; the FSM leaves one cycle later.
                    if (mul_last) begin
                        z_q              <= mul_prod[WIDTH-1:0];
                        z_hi_q           <= mul_prod[2*WIDTH-1:WIDTH];
                        z_valid_q        <= 1'b1;
                        flags_q[FLAG_ZF] <= (mul_prod == '0);
                        flags_q[FLAG_SF] <= mul_prod[2*WIDTH-1];
                    end
                    if (!mul_busy) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign z           = z_q;
    assign z_hi        = z_hi_q;
    assign z_valid     = z_valid_q;
    assign cy          = flags_q[FLAG_CY];
    assign ov          = flags_q[FLAG_OV];
    assign zf          = flags_q[FLAG_ZF];
    assign sf          = flags_q[FLAG_SF];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_superfx_alu_seq.sv
// Scoreboard bench for superfx_alu_seq: directed vectors push expected responses, a monitor pops on z_valid.
// Covers the SUPERFX_ALU_MUL_EN build and the default (multiplier-less) build.
`timescale 1ns/1ps
module tb_superfx_alu_seq;
    import superfx_alu_pkg::*;

    localparam int W  = 16;
    localparam int IW = 8;
`ifdef SUPERFX_ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op;
    logic [W-1:0]  x, y;
    logic [IW-1:0] imm;
    logic          y_src_sel;
    logic [W-1:0]  z, z_hi;
    logic          z_valid, cy, ov, zf, sf;
    state_t        dbg_state;

    superfx_alu_seq #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op          (op),
        .x           (x),
        .y           (y),
        .imm         (imm),
        .y_src_sel   (y_src_sel),
        .z           (z),
        .z_hi        (z_hi),
        .z_valid     (z_valid),
        .cy          (cy),
        .ov          (ov),
        .zf          (zf),
        .sf          (sf),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 2ms", $time);
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [2*W+3:0] exp_q[$];      // {z, z_hi, cy, ov, zf, sf}
    int unsigned    exp_cyc_q[$];  // cycle count at which z_valid must be seen
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [2*W+3:0] e;
        int unsigned    ec;
        forever begin
            @(negedge clk);
            if (z_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_z_valid", z_valid, 1'b0);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("z", z, e[2*W+3:W+4]);
                    check("z_hi", z_hi, e[W+3:4]);
                    check("flags_cy_ov_zf_sf", {cy, ov, zf, sf}, e[3:0]);
                    check("latency_cycle", cyc, ec);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] ya,
                         input logic [IW-1:0] im, input logic sel,
                         input logic [W-1:0] ez, input logic [W-1:0] ezh, input logic [3:0] efl,
                         input bit push);
        int guard = 0;
        @(negedge clk);
        while (op_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("op_ready_timeout", op_ready, 1'b1);
        op_valid  = 1'b1;
        op        = o;
        x         = xa;
        y         = ya;
        imm       = im;
        y_src_sel = sel;
        if (push) begin
            exp_q.push_back({ez, ezh, efl});
            exp_cyc_q.push_back(cyc + 1 + ((o == OP_MUL && MUL_ON) ? W - 1 : 0));
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_z"}, z, '0);
        check({tag, "_z_hi"}, z_hi, '0);
        check({tag, "_z_valid"}, z_valid, 1'b0);
        check({tag, "_flags"}, {cy, ov, zf, sf}, 4'b0000);
        check({tag, "_op_ready"}, op_ready, 1'b1);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int guard;
        int seen;
        reset     = 1'b1;
        op_valid  = 1'b1;
        op        = OP_ADD;
        x         = 16'h0001;
        y         = 16'h0001;
        imm       = '0;
        y_src_sel = 1'b0;

        // reset held two cycles with a request pending
        repeat (2) begin
            @(negedge clk);
            check_reset_state("reset");
        end
        reset    = 1'b0;
        op_valid = 1'b0;

        // flags after each vector: {cy, ov, zf, sf}
        issue(OP_ADD,  16'hFFFF, 16'h0001, 8'h00, 1'b0, 16'h0000, 16'h0, 4'b1010, 1);
        issue(OP_ADC,  16'h0001, 16'h0001, 8'h00, 1'b0, 16'h0003, 16'h0, 4'b0000, 1);
        issue(OP_SUB,  16'h8000, 16'h1234, 8'h01, 1'b1, 16'h7FFF, 16'h0, 4'b1100, 1);
        issue(OP_ROR,  16'h0001, 16'h0000, 8'h00, 1'b0, 16'h8000, 16'h0, 4'b1101, 1);
        issue(OP_ASR,  16'h8002, 16'h0000, 8'h00, 1'b0, 16'hC001, 16'h0, 4'b0101, 1);
        issue(OP_SBC,  16'h0005, 16'h0003, 8'h00, 1'b0, 16'h0001, 16'h0, 4'b1000, 1);
        issue(OP_AND,  16'hF0F0, 16'hFF00, 8'h00, 1'b0, 16'hF000, 16'h0, 4'b1001, 1);
        issue(OP_OR,   16'h0F00, 16'h00F0, 8'h00, 1'b0, 16'h0FF0, 16'h0, 4'b1000, 1);
        issue(OP_XOR,  16'hAAAA, 16'hAAAA, 8'h00, 1'b0, 16'h0000, 16'h0, 4'b1010, 1);
        issue(OP_BIC,  16'hFFFF, 16'h0F0F, 8'h00, 1'b0, 16'hF0F0, 16'h0, 4'b1001, 1);
        issue(OP_LSR,  16'h8001, 16'h0000, 8'h00, 1'b0, 16'h4000, 16'h0, 4'b1000, 1);
        issue(OP_SWAP, 16'h1234, 16'h0000, 8'h00, 1'b0, 16'h3412, 16'h0, 4'b1000, 1);
        issue(4'd13,   16'h1234, 16'h5678, 8'h00, 1'b0, 16'h0000, 16'h0, 4'b1000, 1);
        issue(OP_ADD,  16'h7FFF, 16'h0001, 8'h00, 1'b0, 16'h8000, 16'h0, 4'b0101, 1);
        issue(OP_SUB,  16'h0000, 16'h0001, 8'h00, 1'b0, 16'hFFFF, 16'h0, 4'b0001, 1);
        issue(OP_ADD,  16'h0010, 16'h1234, 8'hFF, 1'b1, 16'h010F, 16'h0, 4'b0000, 1);
        issue(OP_ROR,  16'h0003, 16'h0000, 8'h00, 1'b0, 16'h0001, 16'h0, 4'b1000, 1);
        issue(4'd15,   16'hFFFF, 16'hFFFF, 8'h00, 1'b0, 16'h0000, 16'h0, 4'b1000, 1);

`ifdef SUPERFX_ALU_MUL_EN
        issue(OP_ADD,  16'hFFFF, 16'h0001, 8'h00, 1'b0, 16'h0000, 16'h0,    4'b1010, 1);
        issue(OP_MUL,  16'hFFFF, 16'hFFFF, 8'h00, 1'b0, 16'h0001, 16'hFFFE, 4'b1001, 1);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (i == 0) begin
                op_valid = 1'b0;
                x        = 16'h0000;
                y        = 16'h0000;
            end
            check("mul_busy_op_ready", op_ready, 1'b0);
        end
        @(negedge clk);
        check("mul_done_op_ready", op_ready, 1'b1);

        issue(OP_ADD,  16'h0001, 16'h0001, 8'h00, 1'b0, 16'h0002, 16'h0,    4'b0000, 1);
        issue(OP_MUL,  16'h0000, 16'h1234, 8'h00, 1'b0, 16'h0000, 16'h0000, 4'b0010, 1);
        issue(OP_MUL,  16'h1234, 16'h5678, 8'h10, 1'b1, 16'h2340, 16'h0001, 4'b0000, 1);
        go_idle();

        // reset during the fifth busy cycle aborts the multiply
        issue(OP_MUL,  16'hFFFF, 16'hFFFF, 8'h00, 1'b0, 16'h0000, 16'h0000, 4'b0000, 0);
        repeat (5) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
        reset    = 1'b1;
        op_valid = 1'b1;
        op       = OP_ADD;
        @(negedge clk);
        check_reset_state("mul_abort");
        reset    = 1'b0;
        op_valid = 1'b0;
        seen = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (z_valid === 1'b1) seen++;
        end
        check("mul_abort_z_valid_count", seen, 0);
        issue(OP_ADD,  16'h0001, 16'h0002, 8'h00, 1'b0, 16'h0003, 16'h0,    4'b0000, 1);
`else
        issue(OP_MUL,  16'h1234, 16'h0002, 8'h00, 1'b0, 16'h0000, 16'h0,    4'b1000, 1);
        go_idle();
        check("nomul_op_ready", op_ready, 1'b1);
        issue(OP_ADD,  16'h0001, 16'h0002, 8'h00, 1'b0, 16'h0003, 16'h0,    4'b0000, 1);
`endif
        go_idle();

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
